// File: rtl/ext_intr_arbiter.sv
// ext_intr_arbiter: fixed-priority external interrupt arbiter with claim/complete handshake
module ext_intr_arbiter #(
  parameter int          NUM_SRC    = 8,
  parameter int          CAUSE_BASE = 16,
  parameter logic [31:0] EDGE_MASK  = 32'h0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               claim_i,
  input  logic               complete_i,
  input  logic               cfg_we_i,
  input  logic [1:0]         cfg_addr_i,
  input  logic [31:0]        cfg_wdata_i,
  output logic [31:0]        cfg_rdata_o,
  output logic               m_ext_intr_o,
  output logic [30:0]        mcause_o,
  output logic               busy_o
);
  localparam int ID_W = $clog2(NUM_SRC);

  typedef enum logic [1:0] {IDLE, REQ, SERVING} state_t;

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] enable, enable_nxt, pending, pending_nxt, src_q;
  logic [NUM_SRC-1:0] edge_m, rise, w1c, claim_clr, cand, cand_nxt;
  logic [ID_W-1:0]    active_id, winner;
  logic [30:0]        mcause_q;
  logic [31:0]        enable_rd, pending_rd, status_rd;
  logic               any_cand;
  logic               unused_ok;

  assign unused_ok   = &{1'b0, cfg_wdata_i};
  assign edge_m      = EDGE_MASK[NUM_SRC-1:0];
  assign rise        = src_i & ~src_q & edge_m;
  assign w1c         = (cfg_we_i && cfg_addr_i == 2'd1) ? cfg_wdata_i[NUM_SRC-1:0] : '0;
  assign claim_clr   = (state == REQ && claim_i) ? (NUM_SRC'(1) << active_id) : '0;
  // A new edge beats any clear (W1C or claim) landing in the same cycle
  assign pending_nxt = (edge_m & ((pending & ~(w1c | claim_clr)) | rise)) | (~edge_m & src_i);
  assign enable_nxt  = (cfg_we_i && cfg_addr_i == 2'd0) ? cfg_wdata_i[NUM_SRC-1:0] : enable;
  assign cand        = pending & enable;
  assign cand_nxt    = pending_nxt & enable_nxt;
  assign any_cand    = |cand;

  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (cand[i]) winner = ID_W'(i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      enable  <= '0;
      pending <= '0;
      src_q   <= '0;
    end else begin
      enable  <= enable_nxt;
      pending <= pending_nxt;
      src_q   <= src_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // Withdraw looks at next-cycle candidates so a disabling write drops the request at once
  always_comb begin
    state_nxt = state == IDLE ? (any_cand ? REQ : IDLE) :
                state == REQ  ? (claim_i ? SERVING : (cand_nxt[active_id] ? REQ : IDLE)) :
                                (complete_i ? IDLE : SERVING);
  end

  always_comb begin
    m_ext_intr_o = state == REQ;
    busy_o       = state != IDLE;
    mcause_o     = mcause_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      active_id <= '0;
      mcause_q  <= '0;
    end else if (state == IDLE && any_cand) begin
      active_id <= winner;
      mcause_q  <= 31'(CAUSE_BASE) + 31'(winner);
    end else if (state_nxt == IDLE) begin
      mcause_q  <= '0;
    end
  end

  always_comb begin
    enable_rd                 = '0;
    enable_rd[NUM_SRC-1:0]    = enable;
    pending_rd                = '0;
    pending_rd[NUM_SRC-1:0]   = pending;
    status_rd                 = '0;
    status_rd[31]             = state == SERVING;
    status_rd[30]             = state == REQ;
    status_rd[ID_W-1:0]       = active_id;
    cfg_rdata_o = cfg_addr_i == 2'd0 ? enable_rd :
                  cfg_addr_i == 2'd1 ? pending_rd :
                  cfg_addr_i == 2'd2 ? status_rd : '0;
  end
endmodule

// File: tb/tb_ext_intr_arbiter.sv
// tb_ext_intr_arbiter: table-driven directed checks plus a reset-in-service sequence
module tb_ext_intr_arbiter;
  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  src_i = '0;
  logic        claim_i = 1'b0;
  logic        complete_i = 1'b0;
  logic        cfg_we_i = 1'b0;
  logic [1:0]  cfg_addr_i = '0;
  logic [31:0] cfg_wdata_i = '0;
  logic [31:0] cfg_rdata_o;
  logic        m_ext_intr_o;
  logic [30:0] mcause_o;
  logic        busy_o;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic [7:0]  src;
    logic        claim;
    logic        complete;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        intr;
    logic [30:0] cause;
    logic        busy;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[$];

  always #5 clk_i = ~clk_i;

  ext_intr_arbiter #(.NUM_SRC(8), .CAUSE_BASE(16), .EDGE_MASK(32'h3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .src_i(src_i), .claim_i(claim_i), .complete_i(complete_i),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i),
    .cfg_rdata_o(cfg_rdata_o), .m_ext_intr_o(m_ext_intr_o), .mcause_o(mcause_o), .busy_o(busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic v(input logic [7:0] s, input logic c, input logic m, input logic w,
                   input logic [1:0] a, input logic [31:0] d, input logic i,
                   input logic [30:0] ca, input logic b, input logic [31:0] r);
    tbl.push_back('{s, c, m, w, a, d, i, ca, b, r});
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // level src 3: latency, claim, complete
    v(8'h00, L, L, H, 2'd0, 32'h08,       L, 31'd0,  L, 32'h08);
    v(8'h08, L, L, L, 2'd1, 32'h0,        L, 31'd0,  L, 32'h08);
    v(8'h08, L, L, L, 2'd2, 32'h0,        H, 31'd19, H, 32'h4000_0003);
    v(8'h08, H, L, L, 2'd2, 32'h0,        L, 31'd19, H, 32'h8000_0003);
    v(8'h00, L, H, L, 2'd1, 32'h0,        L, 31'd0,  L, 32'h0);
    v(8'h00, L, L, L, 2'd0, 32'h0,        L, 31'd0,  L, 32'h08);
    // priority between src 2 and 5, upper enable bits read 0
    v(8'h00, L, L, H, 2'd0, 32'hFFFF_FFFF, L, 31'd0, L, 32'hFF);
    v(8'h24, L, L, L, 2'd1, 32'h0,        L, 31'd0,  L, 32'h24);
    v(8'h24, L, L, L, 2'd2, 32'h0,        H, 31'd18, H, 32'h4000_0002);
    v(8'h24, H, L, L, 2'd2, 32'h0,        L, 31'd18, H, 32'h8000_0002);
    v(8'h20, L, H, L, 2'd1, 32'h0,        L, 31'd0,  L, 32'h20);
    v(8'h20, L, L, L, 2'd2, 32'h0,        H, 31'd21, H, 32'h4000_0005);
    v(8'h20, H, L, L, 2'd2, 32'h0,        L, 31'd21, H, 32'h8000_0005);
    v(8'h00, L, H, L, 2'd1, 32'h0,        L, 31'd0,  L, 32'h0);
    // withdraw on disable, claim beats withdraw
    v(8'h40, L, L, L, 2'd1, 32'h0,        L, 31'd0,  L, 32'h40);
    v(8'h40, L, L, L, 2'd2, 32'h0,        H, 31'd22, H, 32'h4000_0006);
    v(8'h40, L, L, H, 2'd0, 32'h0,        L, 31'd0,  L, 32'h0);
    v(8'h40, L, L, H, 2'd0, 32'h40,       L, 31'd0,  L, 32'h40);
    v(8'h40, L, L, L, 2'd2, 32'h0,        H, 31'd22, H, 32'h4000_0006);
    v(8'h40, H, L, H, 2'd0, 32'h0,        L, 31'd22, H, 32'h0);
    v(8'h00, L, H, L, 2'd0, 32'h0,        L, 31'd0,  L, 32'h0);
    // edge src 1 accumulates while serving id 4
    v(8'h10, L, L, H, 2'd0, 32'hFF,       L, 31'd0,  L, 32'hFF);
    v(8'h10, L, L, L, 2'd1, 32'h0,        H, 31'd20, H, 32'h10);
    v(8'h10, H, L, L, 2'd2, 32'h0,        L, 31'd20, H, 32'h8000_0004);
    v(8'h02, L, L, L, 2'd1, 32'h0,        L, 31'd20, H, 32'h02);
    v(8'h00, L, L, L, 2'd1, 32'h0,        L, 31'd20, H, 32'h02);
    v(8'h00, L, H, L, 2'd1, 32'h0,        L, 31'd0,  L, 32'h02);
    v(8'h00, L, L, L, 2'd1, 32'h0,        H, 31'd17, H, 32'h02);
    v(8'h00, H, L, L, 2'd1, 32'h0,        L, 31'd17, H, 32'h00);
    v(8'h00, L, H, L, 2'd1, 32'h0,        L, 31'd0,  L, 32'h00);
    // W1C vs simultaneous edge, W1C on level bits, addr 3
    v(8'h00, L, L, H, 2'd0, 32'h0,        L, 31'd0,  L, 32'h0);
    v(8'h01, L, L, L, 2'd1, 32'h0,        L, 31'd0,  L, 32'h01);
    v(8'h00, L, L, L, 2'd1, 32'h0,        L, 31'd0,  L, 32'h01);
    v(8'h01, L, L, H, 2'd1, 32'h01,       L, 31'd0,  L, 32'h01);
    v(8'h01, L, L, H, 2'd1, 32'h01,       L, 31'd0,  L, 32'h00);
    v(8'h08, L, L, L, 2'd1, 32'h0,        L, 31'd0,  L, 32'h08);
    v(8'h08, L, L, H, 2'd1, 32'h08,       L, 31'd0,  L, 32'h08);
    v(8'h00, L, L, H, 2'd3, 32'hFFFF_FFFF, L, 31'd0, L, 32'h0);
    v(8'h00, L, L, L, 2'd0, 32'h0,        L, 31'd0,  L, 32'h0);
    v(8'h00, L, L, H, 2'd0, 32'h01,       L, 31'd0,  L, 32'h01);
    // edge on active id in the claim cycle keeps it pending
    v(8'h01, L, L, L, 2'd1, 32'h0,        L, 31'd0,  L, 32'h01);
    v(8'h00, L, L, L, 2'd1, 32'h0,        H, 31'd16, H, 32'h01);
    v(8'h01, H, L, L, 2'd1, 32'h0,        L, 31'd16, H, 32'h01);
    v(8'h00, L, H, L, 2'd1, 32'h0,        L, 31'd0,  L, 32'h01);
    v(8'h00, L, L, L, 2'd1, 32'h0,        H, 31'd16, H, 32'h01);
    v(8'h00, H, L, L, 2'd1, 32'h0,        L, 31'd16, H, 32'h00);
    v(8'h00, L, H, L, 2'd1, 32'h0,        L, 31'd0,  L, 32'h00);
    v(8'h00, H, H, L, 2'd1, 32'h0,        L, 31'd0,  L, 32'h00);

    repeat (2) tick();
    check("reset intr", 32'(m_ext_intr_o), 32'h0);
    check("reset cause", 32'(mcause_o), 32'h0);
    check("reset busy", 32'(busy_o), 32'h0);
    rst_ni = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      src_i = tbl[k].src;
      claim_i = tbl[k].claim;
      complete_i = tbl[k].complete;
      cfg_we_i = tbl[k].we;
      cfg_addr_i = tbl[k].addr;
      cfg_wdata_i = tbl[k].wdata;
      tick();
      check($sformatf("v%0d intr", k), 32'(m_ext_intr_o), 32'(tbl[k].intr));
      check($sformatf("v%0d cause", k), 32'(mcause_o), 32'(tbl[k].cause));
      check($sformatf("v%0d busy", k), 32'(busy_o), 32'(tbl[k].busy));
      check($sformatf("v%0d rdata", k), cfg_rdata_o, tbl[k].rdata);
    end
    claim_i = 1'b0;
    complete_i = 1'b0;

    // reset while serving
    cfg_we_i = 1'b1;
    cfg_addr_i = 2'd0;
    cfg_wdata_i = 32'hFF;
    src_i = 8'h08;
    tick();
    cfg_we_i = 1'b0;
    repeat (2) tick();
    check("pre-rst intr", 32'(m_ext_intr_o), 32'h1);
    check("pre-rst cause", 32'(mcause_o), 32'd19);
    claim_i = 1'b1;
    tick();
    claim_i = 1'b0;
    check("pre-rst busy", 32'(busy_o), 32'h1);
    rst_ni = 1'b0;
    src_i = 8'h00;
    tick();
    rst_ni = 1'b1;
    check("post-rst intr", 32'(m_ext_intr_o), 32'h0);
    check("post-rst cause", 32'(mcause_o), 32'h0);
    check("post-rst busy", 32'(busy_o), 32'h0);
    for (int a = 0; a < 4; a++) begin
      cfg_addr_i = 2'(a);
      #1;
      check($sformatf("post-rst reg%0d", a), cfg_rdata_o, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
